// File: rtl/jellyvl_stream_arbiter.sv
// Round-robin N:1 stream arbiter with optional packet lock.
// Registered output stage; ready is combinational from grant state.
module jellyvl_stream_arbiter #(
  parameter int NUM         = 4,
  parameter int DATA_BITS   = 8,
  parameter int ID_BITS     = $clog2(NUM),
  parameter int PACKET_LOCK = 1
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic                     cke,
  input  logic [NUM*DATA_BITS-1:0] s_data,
  input  logic [NUM-1:0]           s_last,
  input  logic [NUM-1:0]           s_valid,
  output logic [NUM-1:0]           s_ready,
  output logic [ID_BITS-1:0]       m_id,
  output logic [DATA_BITS-1:0]     m_data,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [ID_BITS-1:0]   rr_ptr;
  logic [ID_BITS-1:0]   lock_id;
  logic [ID_BITS-1:0]   grant;
  logic [ID_BITS-1:0]   grant_inc;
  logic [ID_BITS:0]     idx;
  logic                 grant_en;
  logic                 out_ready;
  logic                 s_xfer;
  logic                 sel_last;
  logic [DATA_BITS-1:0] sel_data;

  // Reset also blocks acceptance so nothing is consumed during reset
  assign out_ready = (!m_valid || m_ready) && cke && !reset;

  always_comb begin
    grant    = '0;
    grant_en = 1'b0;
    idx      = '0;
    if (state == BUSY) begin
      grant    = lock_id;
      grant_en = 1'b1;
    end else begin
      for (int k = 0; k < NUM; k++) begin
        idx = {1'b0, rr_ptr} + (ID_BITS+1)'(k);
        if (idx >= (ID_BITS+1)'(NUM)) begin
          idx = idx - (ID_BITS+1)'(NUM);
        end
        if (!grant_en && s_valid[idx[ID_BITS-1:0]]) begin
          grant    = idx[ID_BITS-1:0];
          grant_en = 1'b1;
        end
      end
    end
  end

  assign sel_data = s_data[grant*DATA_BITS +: DATA_BITS];
  assign sel_last = s_last[grant];
  assign s_xfer   = grant_en && out_ready && s_valid[grant];

  assign grant_inc = (grant == ID_BITS'(NUM-1))
                   ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (cke) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (s_xfer && PACKET_LOCK != 0) begin
      state_next = sel_last ? IDLE : BUSY;
    end
  end

  always_comb begin
    s_ready = '0;
    if (grant_en && out_ready) begin
      s_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (s_xfer) begin
      if (PACKET_LOCK == 0 || sel_last) begin
        rr_ptr <= grant_inc;
      end
      if (PACKET_LOCK != 0 && !sel_last) begin
        lock_id <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_id    <= '0;
      m_data  <= '0;
    end else if (out_ready) begin
      m_valid <= s_xfer;
      if (s_xfer) begin
        m_last <= sel_last;
        m_id   <= grant;
        m_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_stream_arbiter.sv
// Bench for jellyvl_stream_arbiter: locked and unlocked instances
// driven together, checked against a packet-level reference model.
module tb_jellyvl_stream_arbiter;

  localparam int NUM = 4;
  localparam int DB  = 8;
  localparam int IB  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cke;
  logic [NUM*DB-1:0] s_data;
  logic [NUM-1:0]    s_last;
  logic [NUM-1:0]    s_valid;
  logic              m_ready;

  logic [NUM-1:0] s_ready1, s_ready0;
  logic [IB-1:0]  m_id1, m_id0;
  logic [DB-1:0]  m_data1, m_data0;
  logic           m_last1, m_last0;
  logic           m_valid1, m_valid0;

  int n_chk  = 0;
  int n_fail = 0;

  int mv[2], mid[2], md[2], ml[2], locked[2], ptr[2];

  always #5 clk = ~clk;

  jellyvl_stream_arbiter #(
    .NUM(NUM), .DATA_BITS(DB), .ID_BITS(IB), .PACKET_LOCK(1)
  ) dut1 (
    .reset(reset), .clk(clk), .cke(cke),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready1), .m_id(m_id1), .m_data(m_data1),
    .m_last(m_last1), .m_valid(m_valid1), .m_ready(m_ready)
  );

  jellyvl_stream_arbiter #(
    .NUM(NUM), .DATA_BITS(DB), .ID_BITS(IB), .PACKET_LOCK(0)
  ) dut0 (
    .reset(reset), .clk(clk), .cke(cke),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready0), .m_id(m_id0), .m_data(m_data0),
    .m_last(m_last0), .m_valid(m_valid0), .m_ready(m_ready)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Who would win right now: the packet owner, else first valid from ptr
  function automatic int pick(input int u, input logic [NUM-1:0] v);
    if (locked[u] >= 0) return locked[u];
    for (int k = 0; k < NUM; k++) begin
      if (v[(ptr[u] + k) % NUM]) return (ptr[u] + k) % NUM;
    end
    return -1;
  endfunction

  task automatic set(input logic [NUM-1:0] v, input logic [NUM-1:0] l,
                     input logic mr, input logic ce);
    s_valid = v;
    s_last  = l;
    m_ready = mr;
    cke     = ce;
    s_data  = $urandom;
  endtask

  task automatic step();
    int g[2];
    bit o[2];
    int rdy;
    logic [NUM-1:0]    v;
    logic [NUM-1:0]    l;
    logic [NUM*DB-1:0] d;
    #1;
    v = s_valid;
    l = s_last;
    d = s_data;
    for (int u = 0; u < 2; u++) begin
      g[u] = pick(u, v);
      o[u] = (mv[u] == 0 || m_ready) && cke && !reset;
      rdy  = (o[u] && g[u] >= 0) ? (1 << g[u]) : 0;
      check(u ? "s_ready_lk" : "s_ready_nl",
            u ? int'(s_ready1) : int'(s_ready0), rdy);
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        mv[u] = 0; mid[u] = 0; md[u] = 0; ml[u] = 0;
        locked[u] = -1; ptr[u] = 0;
      end else if (o[u]) begin
        if (g[u] >= 0 && v[g[u]]) begin
          mv[u]  = 1;
          mid[u] = g[u];
          md[u]  = int'(d[g[u]*DB +: DB]);
          ml[u]  = int'(l[g[u]]);
          if (u == 1 && !l[g[u]]) begin
            locked[u] = g[u];
          end else begin
            locked[u] = -1;
            ptr[u] = (g[u] + 1) % NUM;
          end
        end else begin
          mv[u] = 0;
        end
      end
    end
    #1;
    check("m_valid_lk", int'(m_valid1), mv[1]);
    check("m_id_lk",    int'(m_id1),    mid[1]);
    check("m_data_lk",  int'(m_data1),  md[1]);
    check("m_last_lk",  int'(m_last1),  ml[1]);
    check("m_valid_nl", int'(m_valid0), mv[0]);
    check("m_id_nl",    int'(m_id0),    mid[0]);
    check("m_data_nl",  int'(m_data0),  md[0]);
    check("m_last_nl",  int'(m_last0),  ml[0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set(4'b0000, 4'b0000, 1'b1, 1'b1);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int seq[5];
    int alt[4];
    for (int u = 0; u < 2; u++) begin
      mv[u] = 0; mid[u] = 0; md[u] = 0; ml[u] = 0;
      locked[u] = -1; ptr[u] = 0;
    end
    reset = 1'b1;
    set(4'b1111, 4'b1111, 1'b1, 1'b0);
    step();
    check("rst_ready", int'(s_ready1), 0);
    do_reset();

    // single-beat packets rotate 0,1,2,3,0
    seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      set(4'b1111, 4'b1111, 1'b1, 1'b1);
      step();
      check("rr_valid", int'(m_valid1), 1);
      check("rr_id", int'(m_id1), seq[i]);
    end

    // slave 2 holds the grant for its 3-beat packet
    seq = '{2, 2, 2, 3, 0};
    for (int b = 0; b < 5; b++) begin
      set((b < 3) ? 4'b1101 : 4'b1001,
          {1'b1, (b >= 2), 1'b1, 1'b1}, 1'b1, 1'b1);
      step();
      check("pkt_id", int'(m_id1), seq[b]);
    end

    // output stall with m_ready low
    set(4'b1111, 4'b1111, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      set(4'b1111, 4'b1111, 1'b0, 1'b1);
      step();
      check("stall_ready", int'(s_ready1), 0);
      check("stall_valid", int'(m_valid1), 1);
    end
    set(4'b1111, 4'b1111, 1'b1, 1'b1);
    step();

    // unlocked instance alternates between slaves 1 and 2
    do_reset();
    alt = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++) begin
      set(4'b0110, 4'b0000, 1'b1, 1'b1);
      step();
      check("alt_id", int'(m_id0), alt[i]);
    end

    // reset in the middle of slave 3's packet
    do_reset();
    set(4'b1000, 4'b0000, 1'b1, 1'b1);
    step();
    step();
    reset = 1'b1;
    set(4'b1000, 4'b0000, 1'b1, 1'b1);
    step();
    check("rst_mid_valid", int'(m_valid1), 0);
    reset = 1'b0;
    set(4'b1010, 4'b1111, 1'b1, 1'b1);
    step();
    check("rst_mid_id", int'(m_id1), 1);

    // clock-enable stall mid-stream
    set(4'b1111, 4'b0101, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      set(4'b1111, 4'b0101, 1'b1, 1'b0);
      step();
      check("cke_ready", int'(s_ready1), 0);
    end
    for (int i = 0; i < 4; i++) begin
      set(4'b1111, 4'b0101, 1'b1, 1'b1);
      step();
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      set(NUM'($urandom), NUM'($urandom),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) != 0));
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
